// File: rtl/scan_bist_harness_pkg.sv
// Shared types and helpers for the scan BIST harness: FSM state encoding,
// default polynomial/seed, and the Galois step used by both LFSR and MISR.
package scan_bist_harness_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [15:0] DEF_POLY   = 16'hB400;
  localparam logic [15:0] DEF_SEED   = 16'hACE1;
  localparam int          STEP_MAX_W = 64;

  // Right-shifting Galois step; callers zero-extend narrower words so the
  // vacated MSB stays clear.
  function automatic logic [STEP_MAX_W-1:0] galois_step(
    input logic [STEP_MAX_W-1:0] value,
    input logic [STEP_MAX_W-1:0] poly,
    input logic [STEP_MAX_W-1:0] inject
  );
    return (value >> 1) ^ (value[0] ? poly : '0) ^ inject;
  endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// Combinational next-value of a W-bit Galois register with an injected word
// (zero injection gives a plain LFSR step, cone response gives a MISR step).
module galois_lfsr_step
  import scan_bist_harness_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_poly,
  input  logic [W-1:0] i_inject,
  output logic [W-1:0] o_next
);

  assign o_next = W'(galois_step(STEP_MAX_W'(i_value),
                                 STEP_MAX_W'(i_poly),
                                 STEP_MAX_W'(i_inject)));

endmodule

// File: rtl/scan_bist_harness.sv
// Scan BIST harness: shifts LFSR patterns into a scan state register, captures
// the external cone's response into a MISR, and repeats for N patterns.
module scan_bist_harness
  import scan_bist_harness_pkg::*;
#(
  parameter int               STATE_W = 22,
  parameter int               OUT_W   = 1,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED    = DEF_SEED,
  parameter int               CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_patterns,
  input  logic [OUT_W-1:0]   cone_out,
  output logic [STATE_W-1:0] state_q,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pattern_cnt,
  output logic [SIG_W-1:0]   signature
);

  localparam int BIT_W  = $clog2(STATE_W + 1);
  localparam int NCHUNK = (OUT_W + SIG_W - 1) / SIG_W;

  state_e               r_state;
  state_e               w_next_state;
  logic [STATE_W-1:0]   r_state_q;
  logic [SIG_W-1:0]     r_lfsr;
  logic [SIG_W-1:0]     r_misr;
  logic [CNT_W-1:0]     r_pat_cnt;
  logic [CNT_W-1:0]     r_num;
  logic [BIT_W-1:0]     r_bit_cnt;

  logic [SIG_W-1:0]        w_lfsr_next;
  logic [SIG_W-1:0]        w_misr_next;
  logic [SIG_W-1:0]        w_resp;
  logic [CNT_W-1:0]        w_pat_inc;
  logic [NCHUNK*SIG_W-1:0] w_cone_pad;

  assign w_pat_inc = r_pat_cnt + CNT_W'(1);

  // Wide cones are XOR-folded in SIG_W chunks; narrow ones just zero-extend.
  always_comb begin
    w_cone_pad = '0;
    w_cone_pad[OUT_W-1:0] = cone_out;
    w_resp = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      w_resp = w_resp ^ w_cone_pad[k*SIG_W +: SIG_W];
    end
  end

  galois_lfsr_step #(.W(SIG_W)) u_lfsr_step (
    .i_value  (r_lfsr),
    .i_poly   (POLY),
    .i_inject ({SIG_W{1'b0}}),
    .o_next   (w_lfsr_next)
  );

  galois_lfsr_step #(.W(SIG_W)) u_misr_step (
    .i_value  (r_misr),
    .i_poly   (POLY),
    .i_inject (w_resp),
    .o_next   (w_misr_next)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (num_patterns == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == BIT_W'(STATE_W - 1)) begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next_state = (w_pat_inc == r_num) ? S_DONE : S_SHIFT;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_state_q <= '0;
      r_lfsr    <= SEED;
      r_misr    <= '0;
      r_pat_cnt <= '0;
      r_num     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        // A zero-length start still clears the signature so done reports 0.
        S_IDLE: begin
          if (start) begin
            r_num     <= num_patterns;
            r_lfsr    <= SEED;
            r_misr    <= '0;
            r_pat_cnt <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_state_q <= {r_state_q[STATE_W-2:0], r_lfsr[0]};
          r_lfsr    <= w_lfsr_next;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        S_CAPTURE: begin
          r_misr    <= w_misr_next;
          r_pat_cnt <= w_pat_inc;
          r_bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign state_q     = r_state_q;
  assign busy        = (r_state == S_SHIFT) || (r_state == S_CAPTURE);
  assign done        = (r_state == S_DONE);
  assign pattern_cnt = r_pat_cnt;
  assign signature   = r_misr;

endmodule

// File: tb/tb_scan_bist_harness.sv
// Directed bench for scan_bist_harness at STATE_W=4; expected signatures and
// scan states are hand-derived from the 0xACE1 / 0xB400 Galois sequence.
module tb_scan_bist_harness;

  localparam int STATE_W = 4;
  localparam int OUT_W   = 1;
  localparam int SIG_W   = 16;
  localparam int CNT_W   = 16;

  logic               clk;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   num_patterns;
  logic [OUT_W-1:0]   cone_out;
  logic [STATE_W-1:0] state_q;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   pattern_cnt;
  logic [SIG_W-1:0]   signature;

  int n_checks = 0;
  int n_fail   = 0;
  int cone_mode;
  int cyc;
  bit saw_busy;
  bit saw_done;

  scan_bist_harness #(
    .STATE_W (STATE_W),
    .OUT_W   (OUT_W),
    .SIG_W   (SIG_W),
    .POLY    (16'hB400),
    .SEED    (16'hACE1),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_patterns (num_patterns),
    .cone_out     (cone_out),
    .state_q      (state_q),
    .busy         (busy),
    .done         (done),
    .pattern_cnt  (pattern_cnt),
    .signature    (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cone stand-in: constant 0, constant 1, or a bit of the scan state.
  assign cone_out = (cone_mode == 0) ? 1'b0 : (cone_mode == 1) ? 1'b1 : state_q[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues start with n, optionally re-pulses start with N=5 at cycle
  // repulse_at, and returns edges from the sampling edge until done is seen.
  task automatic run(input logic [CNT_W-1:0] n, input int repulse_at,
                     output int cycles, output bit busy_seen);
    busy_seen    = 1'b0;
    num_patterns = n;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    num_patterns = n + 16'd7;
    cycles       = 1;
    while (!done && cycles < 2000) begin
      if (busy) busy_seen = 1'b1;
      if (cycles == repulse_at) begin
        start        = 1'b1;
        num_patterns = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic step_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, done, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    num_patterns = '0;
    cone_mode    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state_q", state_q, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", pattern_cnt, 16'd0);
    chk("rst_sig", signature, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // N=1, cone = state_q[1]: LFSR bits 1,0,0,0 leave state_q=1000, resp 0.
    cone_mode = 2;
    run(16'd1, 0, cyc, saw_busy);
    chk("A_cycles", cyc, 6);
    chk("A_done", done, 1'b1);
    chk("A_state_q", state_q, 4'b1000);
    chk("A_sig", signature, 16'h0000);
    chk("A_cnt", pattern_cnt, 16'd1);
    step_idle("A");
    chk("A_busy_idle", busy, 1'b0);

    cone_mode = 1;
    run(16'd1, 0, cyc, saw_busy);
    chk("B_cycles", cyc, 6);
    chk("B_sig", signature, 16'h0001);
    step_idle("B");

    run(16'd2, 0, cyc, saw_busy);
    chk("C_cycles", cyc, 11);
    chk("C_sig", signature, 16'hB401);
    chk("C_cnt", pattern_cnt, 16'd2);
    step_idle("C");

    run(16'd4, 0, cyc, saw_busy);
    chk("D_cycles", cyc, 21);
    chk("D_sig", signature, 16'hC301);
    repeat (3) @(posedge clk);
    #1;
    chk("D_hold_sig", signature, 16'hC301);
    chk("D_hold_cnt", pattern_cnt, 16'd4);
    chk("D_hold_state_q", state_q, 4'b0011);
    chk("D_hold_busy", busy, 1'b0);
    chk("D_hold_done", done, 1'b0);

    // Data-dependent response: scan states 1000, 0111, 0010 give resp 0,1,1.
    cone_mode = 2;
    run(16'd3, 0, cyc, saw_busy);
    chk("E_cycles", cyc, 16);
    chk("E_sig", signature, 16'hB401);
    chk("E_state_q", state_q, 4'b0010);
    step_idle("E");

    run(16'd0, 0, cyc, saw_busy);
    chk("F_cycles", cyc, 1);
    chk("F_done", done, 1'b1);
    chk("F_busy_seen", saw_busy, 1'b0);
    chk("F_sig", signature, 16'h0000);
    chk("F_cnt", pattern_cnt, 16'd0);
    step_idle("F");

    cone_mode = 0;
    run(16'd100, 0, cyc, saw_busy);
    chk("G_cycles", cyc, 501);
    chk("G_sig", signature, 16'h0000);
    chk("G_cnt", pattern_cnt, 16'd100);
    chk("G_busy_seen", saw_busy, 1'b1);
    step_idle("G");

    cone_mode = 1;
    run(16'd2, 3, cyc, saw_busy);
    chk("H_cycles", cyc, 11);
    chk("H_cnt", pattern_cnt, 16'd2);
    chk("H_sig", signature, 16'hB401);
    step_idle("H");
    chk("H_no_restart", busy, 1'b0);

    // Reset during the shift phase of the third pattern.
    cone_mode    = 2;
    num_patterns = 16'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("I_mid_cnt", pattern_cnt, 16'd2);
    chk("I_mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("I_rst_busy", busy, 1'b0);
    chk("I_rst_done", done, 1'b0);
    chk("I_rst_state_q", state_q, 4'h0);
    chk("I_rst_cnt", pattern_cnt, 16'd0);
    chk("I_rst_sig", signature, 16'h0000);
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("I_no_done", saw_done, 1'b0);
    run(16'd3, 0, cyc, saw_busy);
    chk("I_rerun_cycles", cyc, 16);
    chk("I_rerun_sig", signature, 16'hB401);
    chk("I_rerun_state_q", state_q, 4'b0010);
    step_idle("I");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
